pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. It produces the `go` (advance) and `clear` (flush-to-bubble) controls that the IF_ID, ID_EXE, EX_MEM and MEM_WB buffers consume. It detects load-use hazards, flushes on taken branches and jumps resolved in EXE, and runs a halt/drain/resume state machine for halting syscalls. It sits beside the datapath and drives every pipeline buffer's `go`/`clear_*` inputs.

---
 rtl/pipe_hazard_ctrl.sv | 93 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: go/clear control for the 5-stage MIPS pipeline (load-use, redirect, halt/drain/resume).
// Optional statistics counters are built with `PIPE_STATS_EN`.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             resume,
    output logic             pc_go,
    output logic             if_id_go,
    output logic             id_exe_go,
    output logic             ex_mem_go,
    output logic             mem_wb_go,
    output logic             if_id_clear,
    output logic             id_exe_clear_one,
    output logic             id_exe_clear_two,
    output logic             halted
`ifdef PIPE_STATS_EN
   ,output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] halt_cnt
`endif
);
    localparam int D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]     state;
    logic [D_W-1:0] dcnt;
    logic           run_en, lu, run, rdr, stall, back;

    assign lu = ex_mem_read && ex_rd != '0 &&
                ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    assign run   = run_en && state == S_RUN;
    // halt outranks redirect, and redirect flushes the ID instruction so lu is moot
    assign rdr   = run && !ex_halt && ex_redirect;
    assign stall = run && !ex_halt && !ex_redirect && lu;
    assign back  = run_en && (state == S_RUN || state == S_DRAIN);

    assign pc_go            = run && !stall;
    assign if_id_go         = run && !stall;
    assign id_exe_go        = run;
    assign ex_mem_go        = back;
    assign mem_wb_go        = back;
    assign if_id_clear      = rdr;
    assign id_exe_clear_two = rdr;
    assign id_exe_clear_one = stall;
    assign halted           = state == S_HALTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en <= 1'b0;
            state  <= S_RUN;
            dcnt   <= '0;
        end else begin
            run_en <= 1'b1;
            if (run && ex_halt) begin
                state <= S_DRAIN;
                dcnt  <= D_W'(DRAIN_CYCLES - 1);
            end else if (state == S_DRAIN) begin
                if (dcnt == '0) state <= S_HALTED;
                else dcnt <= dcnt - D_W'(1);
            end else if (state == S_HALTED && resume) begin
                state <= S_RUN;
            end
        end
    end

`ifdef PIPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_cnt  <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (rdr && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (halted && halt_cnt != '1) halt_cnt <= halt_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of reset, load-use, redirect, halt/drain/resume and stats.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_mem_read, ex_redirect, ex_halt, resume;
    logic       pc_go, if_id_go, id_exe_go, ex_mem_go, mem_wb_go;
    logic       if_id_clear, id_exe_clear_one, id_exe_clear_two, halted;
`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, halt_cnt;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .ex_halt(ex_halt), .resume(resume),
        .pc_go(pc_go), .if_id_go(if_id_go), .id_exe_go(id_exe_go),
        .ex_mem_go(ex_mem_go), .mem_wb_go(mem_wb_go),
        .if_id_clear(if_id_clear), .id_exe_clear_one(id_exe_clear_one),
        .id_exe_clear_two(id_exe_clear_two), .halted(halted)
`ifdef PIPE_STATS_EN
       ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .halt_cnt(halt_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // packed view: {pc,if_id,id_exe,ex_mem,mem_wb} go, {if_id_clear,clear_one,clear_two}, halted
    function automatic logic [8:0] outs();
        return {pc_go, if_id_go, id_exe_go, ex_mem_go, mem_wb_go,
                if_id_clear, id_exe_clear_one, id_exe_clear_two, halted};
    endfunction

    task automatic idle();
        {id_rs, id_rt, ex_rd} = '0;
        {id_use_rs, id_use_rt, ex_mem_read, ex_redirect, ex_halt, resume} = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #1 check("in_reset", 32'(outs()), 32'h000);
        rst_n = 1'b1;
        #1 check("pre_first_edge", 32'(outs()), 32'h000);
        cyc(); #1 check("run_default", 32'(outs()), 32'b11111_000_0);

        cyc(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        #1 check("lu_rs", 32'(outs()), 32'b00111_010_0);
        cyc(); ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        #1 check("lu_rd0", 32'(outs()), 32'b11111_000_0);
        cyc(); ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
        #1 check("lu_rt", 32'(outs()), 32'b00111_010_0);
        cyc(); ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_use_rt = 0;
        #1 check("lu_unused_rt", 32'(outs()), 32'b11111_000_0);
        cyc(); ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1; ex_redirect = 1;
        #1 check("redirect_lu", 32'(outs()), 32'b11111_101_0);
        cyc(); resume = 1;
        #1 check("resume_in_run", 32'(outs()), 32'b11111_000_0);

        cyc(); ex_halt = 1;
        #1 check("halt_t", 32'(outs()), 32'b11111_000_0);
        cyc(); ex_halt = 1; ex_redirect = 1; ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
        #1 check("drain1_ignore", 32'(outs()), 32'b00011_000_0);
        cyc(); resume = 1;
        #1 check("drain2", 32'(outs()), 32'b00011_000_0);
        cyc(); #1 check("drain3", 32'(outs()), 32'b00011_000_0);
        cyc(); #1 check("halted1", 32'(outs()), 32'b00000_000_1);
        cyc(); #1 check("halted2", 32'(outs()), 32'b00000_000_1);
        cyc(); #1 check("halted3", 32'(outs()), 32'b00000_000_1);
        cyc(); resume = 1;
        #1 check("halted4_resume", 32'(outs()), 32'b00000_000_1);
        cyc(); #1 check("after_resume", 32'(outs()), 32'b11111_000_0);
`ifdef PIPE_STATS_EN
        check("stall_cnt", stall_cnt, 32'd2);
        check("flush_cnt", flush_cnt, 32'd1);
        check("halt_cnt", halt_cnt, 32'd4);
`endif

        cyc(); ex_halt = 1; ex_redirect = 1;
        #1 check("halt_redirect", 32'(outs()), 32'b11111_000_0);
        cyc(); #1 check("drain_entered", 32'(outs()), 32'b00011_000_0);
        cyc(); rst_n = 1'b0;
        #1 check("reset_mid_drain", 32'(outs()), 32'b00000_000_0);
`ifdef PIPE_STATS_EN
        check("stats_reset", stall_cnt | flush_cnt | halt_cnt, 32'd0);
`endif
        cyc(); rst_n = 1'b1;
        #1 check("release2", 32'(outs()), 32'b00000_000_0);
        cyc(); #1 check("run_after_reset", 32'(outs()), 32'b11111_000_0);
        cyc(); #1 check("still_run", 32'(outs()), 32'b11111_000_0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
